// File: rtl/fpu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_seq_if
//  Purpose  : Operand-issue and result-return handshake bundle for fpu_seq.
//  Revision : 1.0  initial release
// ============================================================================
interface fpu_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int c_w = 1 + EXP_W + MAN_W;

    logic           in_valid;
    logic           in_ready;
    logic [c_w-1:0] num1;
    logic [c_w-1:0] num2;
    logic [3:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [c_w-1:0] result;
    logic [3:0]     flags;

    modport master (
        output in_valid, num1, num2, op, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, num1, num2, op, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fpu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_seq
//  Purpose  : Multicycle add/sub/mul/div FPU, truncating, one op in flight.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic      clk,
    input  logic      rst,
    fpu_seq_if.slave  bus
);
    localparam int c_w         = 1 + EXP_W + MAN_W;
    localparam int c_sig_w     = MAN_W + 1;
    localparam int c_sum_w     = c_sig_w + 4;
    localparam int c_acc_w     = 2 * c_sig_w;
    localparam int c_lw        = $clog2(c_acc_w);
    localparam int c_xw        = EXP_W + c_lw + 2;
    localparam int c_div_steps = MAN_W + 2;
    localparam int c_cw        = $clog2(c_div_steps + 1);
    localparam int c_bias      = 2**(EXP_W-1) - 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_unpack = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_norm   = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_mul = 4'd2;
    localparam logic [3:0] c_op_div = 4'd3;

    localparam logic [EXP_W-1:0]      c_exp_max   = {EXP_W{1'b1}};
    localparam logic [c_w-1:0]        c_nan       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [c_xw-1:0] c_bias_x    = c_xw'(c_bias);
    localparam logic signed [c_xw-1:0] c_exp_max_x = c_xw'(2**EXP_W - 1);
    localparam logic signed [c_xw-1:0] c_zero_x    = '0;
    localparam logic signed [c_xw-1:0] c_unit_x    = c_xw'(c_acc_w - 2);
    localparam logic [c_cw-1:0]        c_cnt_last  = c_cw'(c_div_steps);
    localparam logic [c_lw-1:0]        c_top_pos   = c_lw'(c_acc_w - 1);

    localparam logic [3:0] c_flg_inv = 4'b1000;
    localparam logic [3:0] c_flg_dbz = 4'b0100;
    localparam logic [3:0] c_flg_ovf = 4'b0010;
    localparam logic [3:0] c_flg_unf = 4'b0001;

    function automatic logic [c_w-1:0] f_inf(input logic s);
        return {s, c_exp_max, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [c_w-1:0] f_zero(input logic s);
        return {s, {(c_w-1){1'b0}}};
    endfunction

    logic [2:0]               r_state, w_next;
    logic                     w_in_ready, w_out_valid;
    logic [c_w-1:0]           r_num1, r_num2;
    logic [3:0]               r_op;
    logic                     r_special, r_sign, r_eff_sub;
    logic [c_sig_w-1:0]       r_sig_a, r_sig_b;
    logic [EXP_W-1:0]         r_diff;
    logic signed [c_xw-1:0]   r_exp;
    logic [c_acc_w-1:0]       r_acc;
    logic [c_sig_w:0]         r_rem;
    logic [c_cw-1:0]          r_cnt;
    logic [c_w-1:0]           r_result;
    logic [3:0]               r_flags;

    // ---------------- operand classification and special-value decisions
    logic                     w_s1, w_s2, w_s2e, w_sx, w_swap, w_is_addsub;
    logic [EXP_W-1:0]         w_e1, w_e2;
    logic [MAN_W-1:0]         w_f1, w_f2;
    logic                     w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
    logic [c_sig_w-1:0]       w_sig1, w_sig2;
    logic signed [c_xw-1:0]   w_e1x, w_e2x;
    logic                     w_special;
    logic [c_w-1:0]           w_spec_res;
    logic [3:0]               w_spec_flg;

    always_comb begin
        w_s1        = r_num1[c_w-1];
        w_s2        = r_num2[c_w-1];
        w_e1        = r_num1[c_w-2 -: EXP_W];
        w_e2        = r_num2[c_w-2 -: EXP_W];
        w_f1        = r_num1[MAN_W-1:0];
        w_f2        = r_num2[MAN_W-1:0];
        w_s2e       = (r_op == c_op_sub) ? ~w_s2 : w_s2;
        w_sx        = w_s1 ^ w_s2;
        w_is_addsub = (r_op == c_op_add) || (r_op == c_op_sub);
        w_swap      = r_num2[c_w-2:0] > r_num1[c_w-2:0];
        w_zero1     = (w_e1 == '0);
        w_zero2     = (w_e2 == '0);
        w_inf1      = (w_e1 == c_exp_max) && (w_f1 == '0);
        w_inf2      = (w_e2 == c_exp_max) && (w_f2 == '0);
        w_nan1      = (w_e1 == c_exp_max) && (w_f1 != '0);
        w_nan2      = (w_e2 == c_exp_max) && (w_f2 != '0);
        // Denormals carry no hidden bit: they behave exactly like zero.
        w_sig1      = w_zero1 ? '0 : {1'b1, w_f1};
        w_sig2      = w_zero2 ? '0 : {1'b1, w_f2};
        w_e1x       = c_xw'(w_e1);
        w_e2x       = c_xw'(w_e2);

        w_special  = 1'b1;
        w_spec_res = c_nan;
        w_spec_flg = c_flg_inv;
        if (r_op > c_op_div || w_nan1 || w_nan2) begin
            w_special = 1'b1;
        end else if (w_is_addsub) begin
            if (w_inf1 && w_inf2) begin
                if (w_s1 == w_s2e) begin
                    w_spec_res = f_inf(w_s1);
                    w_spec_flg = '0;
                end
            end else if (w_inf1) begin
                w_spec_res = f_inf(w_s1);
                w_spec_flg = '0;
            end else if (w_inf2) begin
                w_spec_res = f_inf(w_s2e);
                w_spec_flg = '0;
            end else begin
                w_special = 1'b0;
            end
        end else if (r_op == c_op_mul) begin
            if ((w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
                w_special = 1'b1;
            end else if (w_inf1 || w_inf2) begin
                w_spec_res = f_inf(w_sx);
                w_spec_flg = '0;
            end else if (w_zero1 || w_zero2) begin
                w_spec_res = f_zero(w_sx);
                w_spec_flg = '0;
            end else begin
                w_special = 1'b0;
            end
        end else begin
            if ((w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
                w_special = 1'b1;
            end else if (w_inf1) begin
                w_spec_res = f_inf(w_sx);
                w_spec_flg = '0;
            end else if (w_inf2) begin
                w_spec_res = f_zero(w_sx);
                w_spec_flg = '0;
            end else if (w_zero2) begin
                w_spec_res = f_inf(w_sx);
                w_spec_flg = c_flg_dbz;
            end else if (w_zero1) begin
                w_spec_res = f_zero(w_sx);
                w_spec_flg = '0;
            end else begin
                w_special = 1'b0;
            end
        end
    end

    // ---------------- execute datapath: aligned add, divider step
    logic [c_sum_w-1:0]  w_big, w_small, w_sum;
    logic                w_rem_ge;
    logic [c_sig_w-1:0]  w_rem_sub;

    always_comb begin
        w_big     = {1'b0, r_sig_a, 3'b000};
        w_small   = {1'b0, r_sig_b, 3'b000} >> r_diff;
        w_sum     = r_eff_sub ? (w_big - w_small) : (w_big + w_small);
        w_rem_ge  = r_rem >= {1'b0, r_sig_b};
        w_rem_sub = c_sig_w'(r_rem - {1'b0, r_sig_b});
    end

    // ---------------- normalise and pack; unit bit lives at c_acc_w-2
    logic [c_lw-1:0]         w_lead;
    logic signed [c_xw-1:0]  w_lead_x, w_nexp;
    logic [MAN_W-1:0]        w_mant;
    logic [c_w-1:0]          w_pack_res;
    logic [3:0]              w_pack_flg;

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < c_acc_w; i++) begin
            if (r_acc[i]) w_lead = c_lw'(i);
        end
        w_lead_x = c_xw'(w_lead);
        w_nexp   = r_exp + w_lead_x - c_unit_x;
        w_mant   = MAN_W'((r_acc << (c_top_pos - w_lead)) >> (c_acc_w - 1 - MAN_W));

        w_pack_res = {r_sign, w_nexp[EXP_W-1:0], w_mant};
        w_pack_flg = '0;
        if (r_acc == '0) begin
            w_pack_res = '0;
        end else if (w_nexp >= c_exp_max_x) begin
            w_pack_res = f_inf(r_sign);
            w_pack_flg = c_flg_ovf;
        end else if (w_nexp <= c_zero_x) begin
            w_pack_res = f_zero(r_sign);
            w_pack_flg = c_flg_unf;
        end
    end

    // ---------------- control FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = c_st_unpack;
            end
            c_st_unpack: w_next = c_st_exec;
            // Specials spend one idle EXEC cycle so all short paths share one latency.
            c_st_exec: begin
                if (r_op != c_op_div || r_special || r_cnt == c_cnt_last)
                    w_next = c_st_norm;
            end
            c_st_norm: w_next = c_st_done;
            c_st_done: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = c_st_idle;
            end
            default: w_next = c_st_idle;
        endcase
    end

    // ---------------- datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num1    <= '0;
            r_num2    <= '0;
            r_op      <= '0;
            r_special <= 1'b0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_sig_a   <= '0;
            r_sig_b   <= '0;
            r_diff    <= '0;
            r_exp     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_num1  <= bus.num1;
                        r_num2  <= bus.num2;
                        r_op    <= bus.op;
                        r_flags <= '0;
                    end
                end
                c_st_unpack: begin
                    r_special <= w_special;
                    r_eff_sub <= w_s1 ^ w_s2e;
                    r_sig_a   <= (w_is_addsub && w_swap) ? w_sig2 : w_sig1;
                    r_sig_b   <= (w_is_addsub && w_swap) ? w_sig1 : w_sig2;
                    r_diff    <= w_swap ? (w_e2 - w_e1) : (w_e1 - w_e2);
                    r_rem     <= {1'b0, w_sig1};
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    if (w_is_addsub) begin
                        r_sign <= w_swap ? w_s2e : w_s1;
                        r_exp  <= w_swap ? w_e2x : w_e1x;
                    end else begin
                        r_sign <= w_sx;
                        r_exp  <= (r_op == c_op_mul) ? (w_e1x + w_e2x - c_bias_x)
                                                     : (w_e1x - w_e2x + c_bias_x);
                    end
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_flags  <= w_spec_flg;
                    end
                end
                c_st_exec: begin
                    if (!r_special) begin
                        if (w_is_addsub) begin
                            r_acc <= c_acc_w'(w_sum) << (c_acc_w - c_sum_w);
                        end else if (r_op == c_op_mul) begin
                            r_acc <= c_acc_w'(r_sig_a) * c_acc_w'(r_sig_b);
                        end else if (r_cnt == c_cnt_last) begin
                            // Quotient unit bit sits at c_sig_w; move it to the common unit slot.
                            r_acc <= r_acc << (c_sig_w - 2);
                            r_cnt <= '0;
                        end else begin
                            r_acc <= {r_acc[c_acc_w-2:0], w_rem_ge};
                            r_rem <= w_rem_ge ? {w_rem_sub, 1'b0} : {r_rem[c_sig_w-1:0], 1'b0};
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_st_norm: begin
                    if (!r_special) begin
                        r_result <= w_pack_res;
                        r_flags  <= w_pack_flg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_seq
//  Purpose  : Self-checking bench for fpu_seq against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fpu_seq #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        sp;
        logic [3:0]  flg;
        logic [31:0] res;
    } ref_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int msb(input longint unsigned v);
        for (int i = 63; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    // Value-level model: exact integer significands, truncation toward zero.
    function automatic ref_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        ref_t r;
        logic sa, sb, rs, tb;
        int ea, eb, e, p, te;
        bit za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, v, tm;
        logic [22:0] f;
        r  = '0;
        r.sp = 1'b1;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
        ma = za ? 0 : (64'd1 << 23) + a[22:0];
        mb = zb ? 0 : (64'd1 << 23) + b[22:0];
        if (op > 4'd3 || na || nb) begin
            r.res = 32'h7FC0_0000; r.flg = 4'b1000; return r;
        end
        v = 0; e = 0; rs = 1'b0;
        if (op <= 4'd1) begin
            if (op == 4'd1) sb = ~sb;
            if (ia && ib) begin
                if (sa != sb) begin r.res = 32'h7FC0_0000; r.flg = 4'b1000; end
                else r.res = {sa, 8'hFF, 23'd0};
                return r;
            end
            if (ia) begin r.res = {sa, 8'hFF, 23'd0}; return r; end
            if (ib) begin r.res = {sb, 8'hFF, 23'd0}; return r; end
            if (b[30:0] > a[30:0]) begin
                tb = sa; sa = sb; sb = tb;
                te = ea; ea = eb; eb = te;
                tm = ma; ma = mb; mb = tm;
            end
            ma = ma << 3;
            mb = (mb << 3) >> (ea - eb);
            v  = (sa != sb) ? ma - mb : ma + mb;
            rs = sa;
            e  = ea - 26;
            r.sp = 1'b0;
            if (v == 0) return r;
        end else if (op == 4'd2) begin
            rs = sa ^ sb;
            if ((za && ib) || (ia && zb)) begin r.res = 32'h7FC0_0000; r.flg = 4'b1000; return r; end
            if (ia || ib) begin r.res = {rs, 8'hFF, 23'd0}; return r; end
            if (za || zb) begin r.res = {rs, 31'd0}; return r; end
            v = ma * mb;
            e = ea + eb - 127 - 46;
            r.sp = 1'b0;
        end else begin
            rs = sa ^ sb;
            if ((za && zb) || (ia && ib)) begin r.res = 32'h7FC0_0000; r.flg = 4'b1000; return r; end
            if (ia) begin r.res = {rs, 8'hFF, 23'd0}; return r; end
            if (ib) begin r.res = {rs, 31'd0}; return r; end
            if (zb) begin r.res = {rs, 8'hFF, 23'd0}; r.flg = 4'b0100; return r; end
            if (za) begin r.res = {rs, 31'd0}; return r; end
            v = (ma << 24) / mb;
            e = ea - eb + 127 - 24;
            r.sp = 1'b0;
        end
        p = msb(v);
        e = e + p;
        f = (p >= 23) ? 23'(v >> (p - 23)) : 23'(v << (23 - p));
        if (e >= 255)    begin r.res = {rs, 8'hFF, 23'd0}; r.flg = 4'b0010; end
        else if (e <= 0) begin r.res = {rs, 31'd0};        r.flg = 4'b0001; end
        else             r.res = {rs, 8'(e), f};
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input int hold);
        ref_t exp_r;
        int lat, exp_lat;
        logic [31:0] held_res;
        logic [3:0] held_flg;
        bit stable;
        exp_r   = model(a, b, op);
        exp_lat = (op == 4'd3 && !exp_r.sp) ? 28 : 3;
        @(negedge clk);
        check({tag, " in_ready idle"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.num1      = a;
        bus.num2      = b;
        bus.op        = op;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.num1     = $urandom;
        bus.num2     = $urandom;
        bus.op       = 4'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            check({tag, " timeout"}, 0, 1);
            return;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, bus.result, exp_r.res);
        check({tag, " flags"}, bus.flags, exp_r.flg);
        check({tag, " in_ready busy"}, bus.in_ready, 0);
        if (hold > 0) begin
            held_res = bus.result;
            held_flg = bus.flags;
            stable   = 1'b1;
            bus.in_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (bus.result !== held_res || bus.flags !== held_flg ||
                    bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stable = 1'b0;
            end
            check({tag, " hold stable"}, stable, 1);
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, " out_valid after xfer"}, bus.out_valid, 0);
        check({tag, " in_ready after xfer"}, bus.in_ready, 1);
    endtask

    function automatic logic [31:0] rnd_operand();
        int sel;
        logic [7:0] e;
        logic [22:0] f;
        sel = $urandom_range(0, 19);
        f   = 23'($urandom);
        case (sel)
            0:       begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = '0; end
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f = f | 23'd1; end
            3:       e = 8'($urandom_range(1, 10));
            4:       e = 8'($urandom_range(245, 254));
            default: e = 8'($urandom_range(110, 145));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [3:0] op;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.num1      = '0;
        bus.num2      = '0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset result", bus.result, 0);
        check("reset flags", bus.flags, 0);
        rst = 1'b0;

        run_op("add 1+2",      32'h3F80_0000, 32'h4000_0000, 4'd0, 0);
        run_op("sub 1-2",      32'h3F80_0000, 32'h4000_0000, 4'd1, 0);
        run_op("mul 3*-2",     32'h4040_0000, 32'hC000_0000, 4'd2, 0);
        run_op("mul ovf",      32'h7F00_0000, 32'h4000_0000, 4'd2, 0);
        run_op("div 6/3",      32'h40C0_0000, 32'h4040_0000, 4'd3, 0);
        run_op("div by 0",     32'h3F80_0000, 32'h0000_0000, 4'd3, 0);
        run_op("inf-inf",      32'h7F80_0000, 32'h7F80_0000, 4'd1, 0);
        run_op("bad op",       32'h3F80_0000, 32'h4000_0000, 4'd7, 0);
        run_op("cancel",       32'h3F80_0000, 32'h3F80_0000, 4'd1, 0);
        run_op("mul unf",      32'h0080_0000, 32'h0080_0000, 4'd2, 0);
        run_op("backpressure", 32'h3F80_0000, 32'h4000_0000, 4'd0, 10);

        // Abort a divide mid-flight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.num1     = 32'h40C0_0000;
        bus.num2     = 32'h4040_0000;
        bus.op       = 4'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", bus.in_ready, 1);
        check("abort out_valid", bus.out_valid, 0);
        check("abort result", bus.result, 0);
        check("abort flags", bus.flags, 0);
        run_op("add after abort", 32'h4040_0000, 32'h3F80_0000, 4'd0, 0);

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            a  = rnd_operand();
            b  = rnd_operand();
            if (op <= 4'd1 && $urandom_range(0, 2) == 0)
                b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 15))};
            run_op("random", a, b, op, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
